// File: rtl/systolic_pkg.sv
// Shared defaults and data types for the systolic array output path.
package systolic_pkg;

    localparam int DATAWIDTH_output = 32;
    localparam int N_COLS           = 4;

    typedef logic [DATAWIDTH_output-1:0] psum_t;
    typedef psum_t row_t [N_COLS];

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full from empty when the indices coincide.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/systolic_output_deskew.sv
// Re-aligns the staggered bottom-row partial sums into whole rows and queues them
// for a valid/ready consumer, flagging (never back-pressuring) overflow.
module systolic_output_deskew #(
    parameter int N_COLS           = systolic_pkg::N_COLS,
    parameter int DATAWIDTH_output = systolic_pkg::DATAWIDTH_output,
    parameter int FIFO_DEPTH       = 4,
    parameter int ROWS_PER_TILE    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [N_COLS*DATAWIDTH_output-1:0] in_D,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_COLS*DATAWIDTH_output-1:0] out_data,
    output logic                               out_last,
    output logic                               overflow
);

    localparam int DW    = DATAWIDTH_output;
    localparam int RW    = N_COLS * DW;
    localparam int CNT_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS_PER_TILE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_COLS-2:0] vld_pipe_q, vld_pipe_d;
    logic              aligned_valid;
    logic [RW-1:0]     aligned_row;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              pop;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic              overflow_q, overflow_d;

    // Column j arrives j cycles late, so it is held N_COLS-1-j cycles to line up with the last column.
    for (genvar j = 0; j < N_COLS; j++) begin : g_col
        localparam int DEPTH_J = N_COLS - 1 - j;
        if (DEPTH_J == 0) begin : g_pass
            assign aligned_row[j*DW +: DW] = in_D[j*DW +: DW];
        end else begin : g_dly
            logic [DW-1:0] pipe_q [DEPTH_J];
            logic [DW-1:0] pipe_d [DEPTH_J];

            always_comb begin
                pipe_d[0] = in_D[j*DW +: DW];
                for (int k = 1; k < DEPTH_J; k++) begin
                    pipe_d[k] = pipe_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '{default: '0};
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign aligned_row[j*DW +: DW] = pipe_q[DEPTH_J-1];
        end
    end

    always_comb begin
        vld_pipe_d[0] = in_valid;
        for (int k = 1; k < N_COLS - 1; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
        end
    end

    assign aligned_valid = vld_pipe_q[N_COLS-2];
    assign out_valid     = !fifo_empty;
    assign pop           = out_valid && out_ready;
    assign fifo_push     = aligned_valid && (!fifo_full || pop);

    always_comb begin
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q || (aligned_valid && fifo_full && !pop);
        if (pop) begin
            row_cnt_d = (row_cnt_q == CNT_LAST) ? '0 : row_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (aligned_row),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_last = out_valid && (row_cnt_q == CNT_LAST);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Bench for systolic_output_deskew: directed scenarios plus a randomized run, compared
// against a row-queue model of the deskew/FIFO behaviour.
module tb_systolic_output_deskew;
    import systolic_pkg::*;

    localparam int DW            = DATAWIDTH_output;
    localparam int RW            = N_COLS * DW;
    localparam int FIFO_DEPTH    = 4;
    localparam int ROWS_PER_TILE = 4;

    typedef logic [RW-1:0] flat_t;
    typedef struct {
        int    due;
        flat_t data;
    } pend_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] in_D;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          overflow;

    int    pass_cnt  = 0;
    int    fail_cnt  = 0;
    int    total_cnt = 0;
    int    cyc       = 0;

    flat_t mq[$];
    pend_t pend[$];
    int    m_cnt = 0;
    bit    m_ovf = 1'b0;

    flat_t hist_row [N_COLS];
    logic  hist_v   [N_COLS];

    systolic_output_deskew #(
        .N_COLS           (N_COLS),
        .DATAWIDTH_output (DW),
        .FIFO_DEPTH       (FIFO_DEPTH),
        .ROWS_PER_TILE    (ROWS_PER_TILE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_D      (in_D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input flat_t observed, input flat_t expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // A row becomes visible in the queue one cycle after its last column arrives; a full
    // queue drops it unless the head leaves in the same cycle.
    task automatic modelEdge(input logic rs, input logic rdy);
        bit    popped;
        bit    arrive;
        bit    was_full;
        flat_t a;
        popped = (mq.size() != 0) && rdy;
        if (rs) begin
            mq.delete();
            pend.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            arrive = 1'b0;
            a      = '0;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                arrive = 1'b1;
                a      = pend[0].data;
                void'(pend.pop_front());
            end
            was_full = (mq.size() == FIFO_DEPTH);
            if (popped) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % ROWS_PER_TILE;
            end
            if (arrive) begin
                if (!was_full || popped) mq.push_back(a);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic modelCheck();
        bit nonempty;
        nonempty = (mq.size() != 0);
        checkOutput("out_valid", flat_t'(out_valid), flat_t'(nonempty));
        checkOutput("out_data", out_data, nonempty ? mq[0] : flat_t'(0));
        checkOutput("out_last", flat_t'(out_last), flat_t'(nonempty && (m_cnt == ROWS_PER_TILE - 1)));
        checkOutput("overflow", flat_t'(overflow), flat_t'(m_ovf));
    endtask

    // One clock: drive the skewed columns (column j of the row started j cycles ago),
    // advance the model at the edge, then compare just after it.
    task automatic applyStimulus(input logic v, input flat_t row, input logic rdy, input logic rs);
        for (int k = N_COLS - 1; k > 0; k--) begin
            hist_v[k]   = hist_v[k-1];
            hist_row[k] = hist_row[k-1];
        end
        hist_v[0]   = v;
        hist_row[0] = row;
        for (int j = 0; j < N_COLS; j++) begin
            in_D[j*DW +: DW] = hist_v[j] ? hist_row[j][j*DW +: DW] : psum_t'($urandom());
        end
        in_valid  = v;
        out_ready = rdy;
        rst       = rs;
        if (v) pend.push_back('{due: cyc + N_COLS - 1, data: row});
        @(posedge clk);
        modelEdge(rs, rdy);
        cyc++;
        #1;
        modelCheck();
    endtask

    function automatic flat_t randRow();
        flat_t r;
        r = '0;
        for (int j = 0; j < N_COLS; j++) begin
            case ($urandom_range(0, 2))
                0:       r[j*DW +: DW] = psum_t'(32'hFFFF_FFFF);
                1:       r[j*DW +: DW] = psum_t'(32'h8000_0000);
                default: r[j*DW +: DW] = psum_t'($urandom());
            endcase
        end
        return r;
    endfunction

    initial begin
        flat_t rows [5];
        flat_t r1;
        int    issued;
        logic  v;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_D      = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N_COLS; k++) begin
            hist_v[k]   = 1'b0;
            hist_row[k] = '0;
        end
        #1;

        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("reset_valid", flat_t'(out_valid), flat_t'(0));
        checkOutput("reset_data", out_data, flat_t'(0));
        checkOutput("reset_last", flat_t'(out_last), flat_t'(0));
        checkOutput("reset_overflow", flat_t'(overflow), flat_t'(0));

        $display("[TB] single row latency");
        for (int j = 0; j < N_COLS; j++) r1[j*DW +: DW] = psum_t'(100 + j);
        applyStimulus(1'b1, r1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_not_early", flat_t'(out_valid), flat_t'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_valid", flat_t'(out_valid), flat_t'(1));
        checkOutput("t1_data", out_data, {32'd103, 32'd102, 32'd101, 32'd100});
        checkOutput("t1_last", flat_t'(out_last), flat_t'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] back-to-back rows and tile marker");
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) rows[i] = randRow();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rows[i], 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t2_row3_data", out_data, rows[3]);
        checkOutput("t2_row3_last", flat_t'(out_last), flat_t'(1));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t2_row4_data", out_data, rows[4]);
        checkOutput("t2_row4_last", flat_t'(out_last), flat_t'(0));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] overflow with stalled consumer");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) rows[i] = randRow();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rows[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t3_overflow", flat_t'(overflow), flat_t'(1));
        checkOutput("t3_hold_row0", out_data, rows[0]);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t3_sticky", flat_t'(overflow), flat_t'(1));
        checkOutput("t3_drained", flat_t'(out_valid), flat_t'(0));

        $display("[TB] full FIFO with simultaneous pop");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) rows[i] = randRow();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rows[i], 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t4_no_overflow", flat_t'(overflow), flat_t'(0));
        checkOutput("t4_head_row1", out_data, rows[1]);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] reset mid-skew");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("t5_valid", flat_t'(out_valid), flat_t'(0));
        checkOutput("t5_overflow", flat_t'(overflow), flat_t'(0));
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_no_stale", flat_t'(out_valid), flat_t'(0));

        $display("[TB] randomized stalls");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        issued = 0;
        for (int c = 0; c < 400 && issued < 32; c++) begin
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(v, randRow(), logic'($urandom_range(0, 1)), 1'b0);
            if (v) issued++;
        end
        checkOutput("t6_all_issued", flat_t'(issued), flat_t'(32));
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t6_drained", flat_t'(out_valid), flat_t'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
